// File: rtl/branch_redirect_pkg.sv
// Shared types and constants for the branch redirect sequencer.
package branch_redirect_pkg;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_WAIT_SLOT,
    BR_REDIRECT
  } br_state_t;

  localparam int unsigned BR_RESET_ADDR = 0;

endpackage

// File: rtl/branch_stat_counter.sv
// Wrapping event counter with synchronous clear (clear beats increment).
// Only present when BRANCH_REDIRECT_STATS_EN is defined.
`ifdef BRANCH_REDIRECT_STATS_EN
module branch_stat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer honouring the MIPS delay slot; exceptions pre-empt branches.
// Optional statistics counters under BRANCH_REDIRECT_STATS_EN.
//
// state        | meaning
// BR_IDLE      | no redirect outstanding, watching for a taken branch
// BR_WAIT_SLOT | taken branch captured, delay-slot fetch not yet seen
// BR_REDIRECT  | redirect presented to fetch, held until if_ready
module branch_redirect_ctrl
  import branch_redirect_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_stall,
  input  logic                  is_branch_instr,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_address,
  input  logic                  if_slot_valid,
  input  logic                  if_ready,
  input  logic                  exc_valid,
  input  logic [ADDR_WIDTH-1:0] exc_address,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_address,
  output logic                  fetch_hold,
  output logic                  busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  stat_taken,
  output logic [CNT_WIDTH-1:0]  stat_exc
`endif
);

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(BR_RESET_ADDR);

  br_state_t             state_q;
  logic [ADDR_WIDTH-1:0] target_q;
  logic                  cap;
  logic                  handshake;

  // Branches arriving while not idle sit in a delay slot and are ignored.
  assign cap = id_valid & ~id_stall & is_branch_instr & branch_taken &
               (state_q == BR_IDLE);
  assign handshake = redirect_valid & if_ready;
  assign busy      = (state_q != BR_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BR_IDLE;
      target_q         <= RESET_ADDR;
      redirect_valid   <= 1'b0;
      redirect_address <= RESET_ADDR;
      fetch_hold       <= 1'b0;
    end else if (exc_valid) begin
      // Exception wins in every state, discarding any pending branch.
      state_q          <= BR_REDIRECT;
      target_q         <= exc_address;
      redirect_valid   <= 1'b1;
      redirect_address <= exc_address;
      fetch_hold       <= 1'b1;
    end else begin
      case (state_q)
        BR_IDLE: begin
          if (cap) begin
            target_q <= branch_address;
            if (if_slot_valid) begin
              state_q          <= BR_REDIRECT;
              redirect_valid   <= 1'b1;
              redirect_address <= branch_address;
              fetch_hold       <= 1'b1;
            end else begin
              state_q <= BR_WAIT_SLOT;
            end
          end
        end
        BR_WAIT_SLOT: begin
          if (if_slot_valid) begin
            state_q          <= BR_REDIRECT;
            redirect_valid   <= 1'b1;
            redirect_address <= target_q;
            fetch_hold       <= 1'b1;
          end
        end
        BR_REDIRECT: begin
          if (handshake) begin
            state_q          <= BR_IDLE;
            redirect_valid   <= 1'b0;
            redirect_address <= RESET_ADDR;
            fetch_hold       <= 1'b0;
          end
        end
        default: begin
          state_q          <= BR_IDLE;
          redirect_valid   <= 1'b0;
          redirect_address <= RESET_ADDR;
          fetch_hold       <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  branch_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stat_taken (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (cap),
    .count (stat_taken)
  );

  branch_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stat_exc (
    .clk   (clk),
    .rst   (rst),
    .clear (stat_clear),
    .inc   (exc_valid),
    .count (stat_exc)
  );
`else
  if (CNT_WIDTH > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus random traffic
// against a transaction-level model; stats checks when BRANCH_REDIRECT_STATS_EN is set.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_stall, is_branch_instr, branch_taken;
  logic [31:0] branch_address;
  logic        if_slot_valid, if_ready, exc_valid;
  logic [31:0] exc_address;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        fetch_hold, busy;
  logic        stat_clear;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] stat_taken, stat_exc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: "a branch is waiting for its slot" and "a redirect is outstanding".
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_out;
  logic [31:0] m_addr;
  logic [31:0] m_taken, m_exc;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_stall         (id_stall),
    .is_branch_instr  (is_branch_instr),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .if_slot_valid    (if_slot_valid),
    .if_ready         (if_ready),
    .exc_valid        (exc_valid),
    .exc_address      (exc_address),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .fetch_hold       (fetch_hold),
    .busy             (busy)
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .stat_clear       (stat_clear),
    .stat_taken       (stat_taken),
    .stat_exc         (stat_exc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    rst = 0; id_valid = 0; id_stall = 0; is_branch_instr = 0; branch_taken = 0;
    branch_address = 32'h0; if_slot_valid = 0; if_ready = 0; exc_valid = 0;
    exc_address = 32'h0; stat_clear = 0;
  endtask

  task automatic branch(input logic [31:0] tgt, input logic slot);
    id_valid = 1; is_branch_instr = 1; branch_taken = 1;
    branch_address = tgt; if_slot_valid = slot;
  endtask

  // Advance one clock with the currently driven inputs, update the model, compare.
  task automatic step();
    logic        idle, take;
    logic        n_pend, n_out;
    logic [31:0] n_tgt, n_addr, n_taken, n_exc;
    idle = !m_out && !m_pend;
    take = id_valid && !id_stall && is_branch_instr && branch_taken && idle;
    n_pend = m_pend; n_out = m_out; n_tgt = m_tgt; n_addr = m_addr;
    n_taken = m_taken; n_exc = m_exc;
    if (rst) begin
      n_pend = 0; n_out = 0; n_addr = 0; n_taken = 0; n_exc = 0;
    end else begin
      if (stat_clear) begin
        n_taken = 0; n_exc = 0;
      end else begin
        if (take) n_taken = m_taken + 1;
        if (exc_valid) n_exc = m_exc + 1;
      end
      if (exc_valid) begin
        n_out = 1; n_addr = exc_address; n_pend = 0;
      end else if (m_out) begin
        if (if_ready) n_out = 0;
      end else if (m_pend) begin
        if (if_slot_valid) begin n_out = 1; n_addr = m_tgt; n_pend = 0; end
      end else if (take) begin
        if (if_slot_valid) begin n_out = 1; n_addr = branch_address; end
        else begin n_pend = 1; n_tgt = branch_address; end
      end
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_out = n_out; m_tgt = n_tgt; m_addr = n_addr;
    m_taken = n_taken; m_exc = n_exc;
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_out});
    chk("redirect_address", redirect_address, m_out ? m_addr : 32'h0);
    chk("fetch_hold", {31'b0, fetch_hold}, {31'b0, m_out});
    chk("busy", {31'b0, busy}, {31'b0, m_out | m_pend});
`ifdef BRANCH_REDIRECT_STATS_EN
    chk("stat_taken", stat_taken, m_taken);
    chk("stat_exc", stat_exc, m_exc);
`endif
  endtask

  initial begin
    m_pend = 0; m_tgt = 0; m_out = 0; m_addr = 0; m_taken = 0; m_exc = 0;
    quiet();

    // Reset state
    rst = 1; step(); step();
    chk("reset_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset_addr", redirect_address, 32'h0);
    quiet();
    step();

    // Taken branch with slot already fetched: one-cycle latency, two cycles to idle
    branch(32'h00400020, 1); if_ready = 1; step();
    chk("t1_valid", {31'b0, redirect_valid}, 32'h1);
    chk("t1_addr", redirect_address, 32'h00400020);
    chk("t1_hold", {31'b0, fetch_hold}, 32'h1);
    quiet(); if_ready = 1; step();
    chk("t1_idle", {30'b0, busy, redirect_valid}, 32'h0);

    // Slot arrives late: three cycles in WAIT_SLOT with fetch running
    quiet(); branch(32'h00400040, 0); step();
    quiet(); step(); step();
    chk("t2_wait_busy", {31'b0, busy}, 32'h1);
    chk("t2_wait_hold", {31'b0, fetch_hold}, 32'h0);
    if_slot_valid = 1; step();
    chk("t2_valid", {31'b0, redirect_valid}, 32'h1);
    chk("t2_addr", redirect_address, 32'h00400040);
    quiet(); if_ready = 1; step();

    // Fetch back-pressure: redirect held stable for four cycles
    quiet(); branch(32'h00400100, 1); step();
    quiet(); step(); step(); step();
    chk("t3_hold_addr", redirect_address, 32'h00400100);
    chk("t3_hold_valid", {31'b0, redirect_valid}, 32'h1);
    if_ready = 1; step();
    chk("t3_cleared", {31'b0, redirect_valid}, 32'h0);

    // Exception pre-empts a branch waiting for its slot
    quiet(); branch(32'h00400020, 0); step();
    quiet(); exc_valid = 1; exc_address = 32'hBFC00380; step();
    chk("t4_exc_addr", redirect_address, 32'hBFC00380);
    quiet(); if_ready = 1; step();
    quiet(); if_slot_valid = 1; step(); step();
    chk("t4_no_branch", {31'b0, redirect_valid}, 32'h0);

    // Stalled branch is not captured; branch in the delay slot is ignored
    quiet(); branch(32'h00400200, 0); id_stall = 1; step();
    chk("t5_stall", {31'b0, busy}, 32'h0);
    id_stall = 0; step();
    quiet(); branch(32'h00400300, 1); step();
    chk("t5_first_tgt", redirect_address, 32'h00400200);
    quiet(); if_ready = 1; step();

    // Reset while a redirect is outstanding
    quiet(); branch(32'h00400400, 1); step();
    quiet(); rst = 1; step();
    chk("t6_rst", {30'b0, busy, redirect_valid}, 32'h0);
    chk("t6_rst_addr", redirect_address, 32'h0);
    quiet(); step();

`ifdef BRANCH_REDIRECT_STATS_EN
    // Two captures and one exception, then clear
    quiet(); branch(32'h00400500, 1); if_ready = 1; step();
    quiet(); if_ready = 1; step();
    branch(32'h00400600, 1); step();
    quiet(); if_ready = 1; step();
    quiet(); exc_valid = 1; exc_address = 32'h80000180; step();
    chk("t7_taken", stat_taken, 32'd2);
    chk("t7_exc", stat_exc, 32'd1);
    quiet(); stat_clear = 1; if_ready = 1; step();
    chk("t7_clr_taken", stat_taken, 32'd0);
    chk("t7_clr_exc", stat_exc, 32'd0);
    quiet(); step();
`endif

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      id_valid        = $urandom_range(0, 1);
      id_stall        = ($urandom_range(0, 3) == 0);
      is_branch_instr = $urandom_range(0, 1);
      branch_taken    = $urandom_range(0, 1);
      branch_address  = $urandom;
      if_slot_valid   = $urandom_range(0, 1);
      if_ready        = $urandom_range(0, 1);
      exc_valid       = ($urandom_range(0, 19) == 0);
      exc_address     = $urandom;
      stat_clear      = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
